bp_cacc_mac_stream: RTL
=======================

BP_CACC_MAC_STREAM -- requirements
Module: bp_cacc_mac_stream

Interface
REQ-001 SHALL have parameter data_width_p, default 64, element and result width.
REQ-002 SHALL have parameter len_width_p, default 8, width of element count.
REQ-003 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_i  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start_v_i  input  1  job start request.
REQ-006 SHALL have port start_len_i  input  len_width_p  number of element pairs in the job.
REQ-007 SHALL have port start_ready_o  output  1  block can accept a start.
REQ-008 SHALL have port elem_v_i  input  1  element pair valid.
REQ-009 SHALL have port a_i  input  data_width_p  operand A element.
REQ-010 SHALL have port b_i  input  data_width_p  operand B element.
REQ-011 SHALL have port elem_ready_o  output  1  block accepts an element pair this cycle.
REQ-012 SHALL have port res_o  output  data_width_p  dot-product result.
REQ-013 SHALL have port res_v_o  output  1  result valid.
REQ-014 SHALL have port res_yumi_i  input  1  consumer takes result; legal only while res_v_o is high.
REQ-015 SHALL have port busy_o  output  1  high in every state except e_idle.

Function
REQ-016 SHALL implement states e_idle, e_accum, e_drain, e_done.
REQ-017 start_ready_o SHALL equal (state == e_idle); a start is accepted on start_v_i & start_ready_o.
REQ-018 On an accepted start with start_len_i > 0: latch remaining count = start_len_i, clear accumulator and pipeline, go to e_accum.
REQ-019 On an accepted start with start_len_i == 0: clear accumulator, go directly to e_done; res_v_o high the next cycle with res_o = 0.
REQ-020 elem_ready_o SHALL be high only in e_accum with remaining count > 0; pairs presented in any other state are ignored and not consumed.
REQ-021 Each accepted pair (elem_v_i & elem_ready_o) SHALL decrement the remaining count by one.
REQ-022 Stage 1 SHALL register the product a_i * b_i truncated to the low data_width_p bits (unsigned), with a stage-1 valid bit.
REQ-023 Stage 2 SHALL add the valid stage-1 product into the accumulator, modulo 2^data_width_p (wrap-around, no saturation, no overflow flag).
REQ-024 When the last pair is accepted, SHALL move e_accum -> e_drain; e_drain -> e_done once stage 1 holds no valid product.
REQ-025 Latency: res_v_o SHALL rise exactly 2 cycles after the cycle in which the last pair is accepted.
REQ-026 elem_v_i gaps SHALL be tolerated without limit; pipeline advances only with accepted pairs.
REQ-027 In e_done, res_v_o = 1 and res_o = accumulator, held stable until res_yumi_i.
REQ-028 res_yumi_i in e_done SHALL move to e_idle next cycle; a start_v_i in that same cycle is not accepted (start_ready_o low).
REQ-029 start_v_i outside e_idle SHALL be ignored and SHALL NOT alter the running job.
REQ-030 res_yumi_i while res_v_o is low SHALL have no effect.

Reset
REQ-031 While reset_i is high, next state SHALL be e_idle; count, accumulator, stage-1 valid cleared.
REQ-032 Reset values: start_ready_o = 1, elem_ready_o = 0, res_v_o = 0, res_o = 0, busy_o = 0.
REQ-033 Reset asserted mid-job SHALL abandon the job with no result produced; first start after reset behaves as from power-up.

Verification
REQ-034 start len=4; pairs (1,5),(2,6),(3,7),(4,8) back-to-back -> res_v_o 2 cycles after 4th accept, res_o = 70; yumi -> e_idle.
REQ-035 start len=0 -> elem_ready_o never high; res_v_o next cycle with res_o = 0.
REQ-036 len=2, pairs (2^63,2),(2^64-1,1) with 3 idle cycles between -> res_o = 2^64-1 (product and sum wrap).
REQ-037 Hold res_yumi_i low 10 cycles in e_done; drive start_v_i and elem_v_i -> res_o stable, no state change, no pairs consumed.
REQ-038 len=8, assert reset_i after 3 pairs -> all outputs at reset values next cycle; new start len=1 pair (3,3) -> res_o = 9.

Source files
------------

// File: rtl/bp_cacc_mac_stream.sv
`default_nettype none
// ============================================================================
// Module   : bp_cacc_mac_stream
// Purpose  : Streaming multiply-accumulate (dot-product) engine.
//            A job starts with a length. Element pairs (a_i, b_i) are then
//            multiplied in stage 1 and summed into the accumulator in stage 2.
//            All arithmetic is unsigned and wraps modulo 2^data_width_p. The
//            result is held on res_o until the consumer takes it with
//            res_yumi_i.
// Ports    : clk_i          - sole clock, rising edge
//            reset_i        - synchronous active-high reset
//            start_v_i      - job start request
//            start_len_i    - number of element pairs in the job
//            start_ready_o  - block can accept a start (idle)
//            elem_v_i       - element pair valid
//            a_i, b_i       - operand elements
//            elem_ready_o   - an element pair is accepted this cycle
//            res_o          - dot-product result
//            res_v_o        - result valid
//            res_yumi_i     - consumer takes result
//            busy_o         - a job or result is in flight
// Revision : 1.0 - initial release
// ============================================================================
module bp_cacc_mac_stream #(
    parameter int data_width_p = 64,
    parameter int len_width_p  = 8
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    start_v_i,
    input  logic [len_width_p-1:0]  start_len_i,
    output logic                    start_ready_o,
    input  logic                    elem_v_i,
    input  logic [data_width_p-1:0] a_i,
    input  logic [data_width_p-1:0] b_i,
    output logic                    elem_ready_o,
    output logic [data_width_p-1:0] res_o,
    output logic                    res_v_o,
    input  logic                    res_yumi_i,
    output logic                    busy_o
);

    typedef enum logic [1:0] {
        e_idle  = 2'd0,
        e_accum = 2'd1,
        e_drain = 2'd2,
        e_done  = 2'd3
    } state_e;

    state_e                  r_state;
    logic [len_width_p-1:0]  r_count;
    logic [data_width_p-1:0] r_acc;
    logic [data_width_p-1:0] r_s1_prod;
    logic                    r_s1_v;

    logic                    w_start_acc;
    logic                    w_elem_acc;
    logic [data_width_p-1:0] w_prod;

    // Operands and target are all data_width_p wide, so the product is the
    // low data_width_p bits of the full product.
    assign w_prod      = a_i * b_i;

    assign start_ready_o = (r_state == e_idle);
    assign elem_ready_o  = (r_state == e_accum) && (r_count != '0);
    assign res_v_o       = (r_state == e_done);
    assign busy_o        = (r_state != e_idle);
    assign res_o         = r_acc;

    assign w_start_acc = start_v_i & start_ready_o;
    assign w_elem_acc  = elem_v_i & elem_ready_o;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state   <= e_idle;
            r_count   <= '0;
            r_acc     <= '0;
            r_s1_prod <= '0;
            r_s1_v    <= 1'b0;
        end else begin
            // Pipeline only advances on accepted pairs; gaps leave it idle.
            r_s1_v <= w_elem_acc;
            if (w_elem_acc) begin
                r_s1_prod <= w_prod;
            end
            if (r_s1_v) begin
                r_acc <= r_acc + r_s1_prod;
            end

            case (r_state)
                e_idle: begin
                    if (w_start_acc) begin
                        r_acc   <= '0;
                        r_s1_v  <= 1'b0;
                        r_count <= start_len_i;
                        if (start_len_i == '0) begin
                            r_state <= e_done;
                        end else begin
                            r_state <= e_accum;
                        end
                    end
                end
                e_accum: begin
                    if (w_elem_acc) begin
                        r_count <= r_count - 1'b1;
                        if (r_count == {{(len_width_p-1){1'b0}}, 1'b1}) begin
                            r_state <= e_drain;
                        end
                    end
                end
                e_drain: begin
                    // No pairs are accepted here, so the final product is
                    // folded into the accumulator on this edge and stage 1
                    // is empty from the next cycle on.
                    r_state <= e_done;
                end
                e_done: begin
                    if (res_yumi_i) begin
                        r_state <= e_idle;
                    end
                end
                default: r_state <= e_idle;
            endcase
        end
    end

endmodule
`default_nettype wire
